// File: rtl/v2f_seq_div_if.sv
// +-----------------------------------------------------------------------+
// | v2f_seq_div_if : operand/result handshake bundle for v2f_seq_div       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

interface v2f_seq_div_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int Y_WIDTH = 8
);
  logic [A_WIDTH-1:0] A;
  logic [B_WIDTH-1:0] B;
  logic               IN_VALID;
  logic               IN_READY;
  logic [Y_WIDTH-1:0] Y;
  logic [Y_WIDTH-1:0] R;
  logic               DZ;
  logic               OUT_VALID;
  logic               OUT_READY;

  modport master (
    output A, B, IN_VALID, OUT_READY,
    input  IN_READY, Y, R, DZ, OUT_VALID
  );

  modport slave (
    input  A, B, IN_VALID, OUT_READY,
    output IN_READY, Y, R, DZ, OUT_VALID
  );
endinterface

`default_nettype wire

// File: rtl/v2f_seq_div.sv
// +-----------------------------------------------------------------------+
// | v2f_seq_div : multi-cycle radix-2 restoring divider (quotient+rem)     |
// | Optional macro V2F_SEQ_DIV_EARLY_EXIT_EN skips CALC when B==0|A|<|B|  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module v2f_seq_div #(
  parameter bit A_SIGNED = 1'b0,
  parameter bit B_SIGNED = 1'b0,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int Y_WIDTH  = 8
) (
  input  logic          CLK,
  input  logic          ARST,
  v2f_seq_div_if.slave  bus
);

  localparam int W      = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int CW     = (W > 1) ? $clog2(W) : 1;
  localparam bit SIGNED = A_SIGNED && B_SIGNED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [Y_WIDTH-1:0] r_q, r_d;

  logic [W-1:0] a_sx, b_sx, a_ext, b_ext, a_mag, b_mag;
  logic         a_neg, b_neg;
  logic [W:0]   shift_w, diff_w;
  logic         q_bit;
  logic [W-1:0] quo_next, rem_next, q_res, r_res;

  function automatic logic [Y_WIDTH-1:0] fit(input logic [W-1:0] v);
    if (SIGNED) fit = Y_WIDTH'($signed(v));
    else        fit = Y_WIDTH'(v);
  endfunction

  // Operand extension and magnitude; the most-negative value maps to 2^(W-1) unsigned.
  always_comb begin
    a_sx  = W'($signed(bus.A));
    b_sx  = W'($signed(bus.B));
    a_ext = SIGNED ? a_sx : W'(bus.A);
    b_ext = SIGNED ? b_sx : W'(bus.B);
    a_neg = SIGNED && a_ext[W-1];
    b_neg = SIGNED && b_ext[W-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  // One restoring step: quo_q shifts dividend bits out of the MSB and quotient bits in at the LSB.
  always_comb begin
    shift_w  = {rem_q, quo_q[W-1]};
    diff_w   = shift_w - {1'b0, div_q};
    q_bit    = ~diff_w[W];
    rem_next = q_bit ? diff_w[W-1:0] : shift_w[W-1:0];
    quo_next = (quo_q << 1) | W'(q_bit);
    q_res    = qneg_q ? -quo_next : quo_next;
    r_res    = rneg_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    y_d     = y_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          quo_d   = a_mag;
          rem_d   = '0;
          div_d   = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (b_ext == '0);
          cnt_d   = CW'(W - 1);
          state_d = CALC;
`ifdef V2F_SEQ_DIV_EARLY_EXIT_EN
          if ((b_ext == '0) || (a_mag < b_mag)) begin
            y_d     = '0;
            r_d     = (b_ext == '0) ? '0 : fit(a_ext);
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          y_d     = dz_q ? '0 : fit(q_res);
          r_d     = dz_q ? '0 : fit(r_res);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      y_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.R         = r_q;
  assign bus.DZ        = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_v2f_seq_div.sv
// +-----------------------------------------------------------------------+
// | tb_v2f_seq_div : directed bench for unsigned and signed 8-bit dividers |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_v2f_seq_div;

`ifdef V2F_SEQ_DIV_EARLY_EXIT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 9;
`endif
  localparam int LAT = 9;

  logic CLK = 1'b0;
  logic ARST;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  v2f_seq_div_if #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8)) u_if ();
  v2f_seq_div_if #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8)) s_if ();

  v2f_seq_div #(.A_SIGNED(1'b0), .B_SIGNED(1'b0), .A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8))
    u_dut (.CLK(CLK), .ARST(ARST), .bus(u_if));
  v2f_seq_div #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8))
    s_dut (.CLK(CLK), .ARST(ARST), .bus(s_if));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input bit sg); return sg ? s_if.OUT_VALID : u_if.OUT_VALID; endfunction
  function automatic logic get_ir(input bit sg); return sg ? s_if.IN_READY : u_if.IN_READY; endfunction
  function automatic logic get_dz(input bit sg); return sg ? s_if.DZ : u_if.DZ; endfunction
  function automatic logic [7:0] get_y(input bit sg); return sg ? s_if.Y : u_if.Y; endfunction
  function automatic logic [7:0] get_r(input bit sg); return sg ? s_if.R : u_if.R; endfunction

  task automatic set_in(input bit sg, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sg) begin s_if.IN_VALID = v; s_if.A = a; s_if.B = b; end
    else    begin u_if.IN_VALID = v; u_if.A = a; u_if.B = b; end
  endtask

  task automatic set_or(input bit sg, input logic v);
    if (sg) s_if.OUT_READY = v;
    else    u_if.OUT_READY = v;
  endtask

  // Presents operands for one edge, then scrambles them so late changes would show up.
  task automatic start(input bit sg, input logic [7:0] a, input logic [7:0] b, input string tag);
    @(negedge CLK);
    set_in(sg, 1'b1, a, b);
    @(posedge CLK); #1;
    set_in(sg, 1'b0, ~a, ~b);
    check({tag, "_ir_after_accept"}, 32'(get_ir(sg)), 32'd0);
  endtask

  task automatic wait_result(input bit sg, input int lat, input logic [7:0] ey,
                             input logic [7:0] er, input logic edz, input string tag);
    int n = 1;
    while (!get_ov(sg) && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_y"},   32'(get_y(sg)), 32'(ey));
    check({tag, "_r"},   32'(get_r(sg)), 32'(er));
    check({tag, "_dz"},  32'(get_dz(sg)), 32'(edz));
  endtask

  task automatic release_out(input bit sg, input string tag);
    @(negedge CLK);
    set_or(sg, 1'b1);
    @(posedge CLK); #1;
    check({tag, "_ir_idle"}, 32'(get_ir(sg)), 32'd1);
    check({tag, "_ov_low"},  32'(get_ov(sg)), 32'd0);
    set_or(sg, 1'b0);
  endtask

  initial begin
    ARST = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 8'd0);
    set_in(1'b1, 1'b0, 8'd0, 8'd0);
    set_or(1'b0, 1'b0);
    set_or(1'b1, 1'b0);
    #12;
    check("rst_ir", 32'(u_if.IN_READY), 32'd1);
    check("rst_ov", 32'(u_if.OUT_VALID), 32'd0);
    check("rst_y",  32'(u_if.Y), 32'd0);
    check("rst_r",  32'(u_if.R), 32'd0);
    check("rst_dz", 32'(u_if.DZ), 32'd0);
    @(negedge CLK);
    ARST = 1'b0;

    start(1'b0, 8'd200, 8'd7, "u200_7");
    wait_result(1'b0, LAT, 8'd28, 8'd4, 1'b0, "u200_7");
    release_out(1'b0, "u200_7");

    start(1'b1, 8'hF9, 8'h02, "s_m7_2");
    wait_result(1'b1, LAT, 8'hFD, 8'hFF, 1'b0, "s_m7_2");
    release_out(1'b1, "s_m7_2");

    start(1'b1, 8'h07, 8'hFE, "s_7_m2");
    wait_result(1'b1, LAT, 8'hFD, 8'h01, 1'b0, "s_7_m2");
    release_out(1'b1, "s_7_m2");

    start(1'b0, 8'd5, 8'd0, "u5_0");
    wait_result(1'b0, LAT_SHORT, 8'd0, 8'd0, 1'b1, "u5_0");
    release_out(1'b0, "u5_0");

    start(1'b0, 8'd3, 8'd10, "u3_10");
    wait_result(1'b0, LAT_SHORT, 8'd0, 8'd3, 1'b0, "u3_10");
    release_out(1'b0, "u3_10");

    start(1'b1, 8'h80, 8'hFF, "s_ovf");
    wait_result(1'b1, LAT, 8'h80, 8'h00, 1'b0, "s_ovf");
    release_out(1'b1, "s_ovf");

    // Backpressure: result must hold and new operands must wait.
    start(1'b0, 8'd90, 8'd4, "bp");
    wait_result(1'b0, LAT, 8'd22, 8'd2, 1'b0, "bp");
    @(negedge CLK);
    set_in(1'b0, 1'b1, 8'd50, 8'd6);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("bp_hold_y",  32'(u_if.Y), 32'd22);
      check("bp_hold_r",  32'(u_if.R), 32'd2);
      check("bp_hold_ir", 32'(u_if.IN_READY), 32'd0);
      check("bp_hold_ov", 32'(u_if.OUT_VALID), 32'd1);
    end
    @(negedge CLK);
    u_if.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    check("bp_idle_ir", 32'(u_if.IN_READY), 32'd1);
    u_if.OUT_READY = 1'b0;
    @(posedge CLK); #1;
    check("bp_accept_ir", 32'(u_if.IN_READY), 32'd0);
    set_in(1'b0, 1'b0, 8'hAA, 8'h55);
    wait_result(1'b0, LAT, 8'd8, 8'd2, 1'b0, "bp50_6");
    release_out(1'b0, "bp50_6");

    // Asynchronous reset in the middle of a calculation.
    start(1'b0, 8'd123, 8'd5, "abort");
    repeat (3) @(posedge CLK);
    #1;
    check("abort_ov_calc", 32'(u_if.OUT_VALID), 32'd0);
    @(negedge CLK);
    ARST = 1'b1;
    #1;
    check("arst_ir", 32'(u_if.IN_READY), 32'd1);
    check("arst_ov", 32'(u_if.OUT_VALID), 32'd0);
    check("arst_y",  32'(u_if.Y), 32'd0);
    check("arst_r",  32'(u_if.R), 32'd0);
    @(negedge CLK);
    ARST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("abort_no_ov", 32'(u_if.OUT_VALID), 32'd0);
    end
    start(1'b0, 8'd100, 8'd9, "u100_9");
    wait_result(1'b0, LAT, 8'd11, 8'd1, 1'b0, "u100_9");
    release_out(1'b0, "u100_9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/v2f_seq_div.md
Name: v2f_seq_div

Overview:
- Multi-cycle radix-2 restoring divider. Produces quotient and remainder in one operation.
- Sits directly upstream of the blackbox arithmetic stage: the techmap instantiates it in place of a combinational v2f_div/v2f_mod pair when a registered, handshaked result is wanted.
- Its outputs feed v2f_pmux/v2f_add consumers.
- Result semantics match the combinator divide: truncate toward zero, and divide-by-zero gives 0.

Parameters:
- A_SIGNED, 0, dividend signed flag.
- B_SIGNED, 0, divisor signed flag. The operation is signed only when A_SIGNED && B_SIGNED.
- A_WIDTH, 8, dividend width (1..32).
- B_WIDTH, 8, divisor width (1..32).
- Y_WIDTH, 8, width of quotient Y and remainder R.

Ports:
- CLK  input  1  rising-edge clock
- ARST  input  1  asynchronous reset, active-high
- A  input  A_WIDTH  dividend
- B  input  B_WIDTH  divisor
- IN_VALID  input  1  operand valid
- IN_READY  output  1  block can accept operands
- Y  output  Y_WIDTH  quotient
- R  output  Y_WIDTH  remainder
- DZ  output  1  divisor was zero
- OUT_VALID  output  1  Y/R/DZ valid
- OUT_READY  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, CLK. Reset ARST is asynchronous and active-high.
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, Y=0, R=0, DZ=0, all internal registers 0.
- Internal width: W = max(A_WIDTH, B_WIDTH). Operands are sign- or zero-extended to W per the signed rule.
- IDLE state:
  - IN_READY=1. Accept occurs on an edge with IN_VALID&&IN_READY.
  - On accept: latch |A| and |B|, the result-sign flags (qneg = sA^sB, rneg = sA), and DZ=(B==0). Go to CALC with counter = W-1.
- CALC state:
  - IN_READY=0. One quotient bit per edge, MSB first.
  - Shift remainder left, bring in the next dividend bit, trial-subtract |B|, keep the result if non-negative.
  - Counter decrements each edge. Transition to DONE on the edge where counter==0.
- DONE state:
  - OUT_VALID=1. Y and R are registered and stable.
  - Y = qneg ? -q : q, R = rneg ? -r : r, each truncated or sign/zero-extended to Y_WIDTH.
  - Go to IDLE on the edge with OUT_READY=1. Hold all outputs while OUT_READY=0.
- Latency: OUT_VALID rises W+1 edges after the accept edge (9 for W=8).
- No overlap: IN_READY=0 in both CALC and DONE, so a new operand is accepted only in IDLE. There is no combinational path from OUT_READY to IN_READY.
- Divide-by-zero: the CALC cycles still run (fixed latency), but in DONE the block forces Y=0, R=0, DZ=1.
- Signed overflow (most-negative / -1): the quotient wraps modulo 2^Y_WIDTH, R=0, DZ=0.
- IN_VALID while not ready is ignored. A and B are sampled only on the accept edge, so changing them afterwards has no effect.
- ARST asserted in any state returns everything to reset values immediately. After release, the first accept starts a clean operation; the aborted operation never produces OUT_VALID.

Optional Feature:
- Macro: V2F_SEQ_DIV_EARLY_EXIT_EN.
- Defined: on accept, if B==0 or |A|<|B|, go directly IDLE->DONE. OUT_VALID rises 1 edge after accept, with Y=0 and R=A (or Y=0, R=0, DZ=1 for a zero divisor).
- Undefined: latency is always W+1 edges.

Test Plan:
- Unsigned, all widths 8, A=200, B=7 -> after 9 edges OUT_VALID=1, Y=28, R=4, DZ=0.
- Signed (both flags 1), A=0xF9 (-7), B=2 -> Y=0xFD (-3), R=0xFF (-1). A=7, B=0xFE -> Y=0xFD, R=0x01.
- A=5, B=0 -> Y=0, R=0, DZ=1. Latency 9 without the macro, 1 with V2F_SEQ_DIV_EARLY_EXIT_EN. Also A=3, B=10 with the macro -> Y=0, R=3 after 1 edge.
- Signed A=0x80, B=0xFF -> Y=0x80, R=0, DZ=0.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID, with IN_VALID=1 and new operands -> Y/R stable, IN_READY=0, no accept. Raise OUT_READY -> IDLE next edge, then the new operand is accepted.
- Assert ARST for 1 cycle mid-CALC (4 edges after accept) -> IN_READY=1, OUT_VALID=0, Y=R=0 immediately. A following 100/9 yields Y=11, R=1.
